// File: rtl/icache_controller.sv
// Direct-mapped instruction cache: zero-latency hits, blocking 128-bit line refill on a miss.
// Optional hit/miss counters are enabled with `define ICACHE_PERF_EN.
module icache_controller #(
    parameter int unsigned NUM_LINES  = 8,
    parameter int unsigned INDEX_BITS = 3
) (
    input  logic         CLK,
    input  logic         RESET_N,
    input  logic         PC_READ,
    input  logic [31:0]  PC_ADDRESS,
    output logic [31:0]  INSTRUCTION,
    output logic         CPU_BUSYWAIT,
    input  logic         FLUSH,
    output logic         MEM_READ,
    output logic [27:0]  MEM_ADDRESS,
    input  logic [127:0] MEM_READDATA,
    input  logic         MEM_BUSYWAIT
`ifdef ICACHE_PERF_EN
    ,
    output logic [31:0]  HIT_COUNT,
    output logic [31:0]  MISS_COUNT
`endif
);
    localparam int unsigned TAG_W = 28 - INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        MEM_READ_S = 2'd1,
        UPDATE     = 2'd2
    } state_t;

    state_t                r_state;
    logic                  r_armed;
    logic [27:0]           r_miss_addr;
    logic [NUM_LINES-1:0]  r_valid;
    logic [TAG_W-1:0]      r_tag  [NUM_LINES];
    logic [127:0]          r_data [NUM_LINES];

    logic [INDEX_BITS-1:0] w_idx;
    logic [TAG_W-1:0]      w_tag;
    logic [1:0]            w_word;
    logic [INDEX_BITS-1:0] w_fill_idx;
    logic [TAG_W-1:0]      w_fill_tag;
    logic                  w_hit;
    logic                  w_idle;
    logic                  w_miss;
    logic                  w_unused;

    assign w_idx      = PC_ADDRESS[3+INDEX_BITS:4];
    assign w_tag      = PC_ADDRESS[31:4+INDEX_BITS];
    assign w_word     = PC_ADDRESS[3:2];
    assign w_fill_idx = r_miss_addr[INDEX_BITS-1:0];
    assign w_fill_tag = r_miss_addr[27:INDEX_BITS];
    assign w_unused   = ^PC_ADDRESS[1:0];

    assign w_hit  = PC_READ & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_idle = (r_state == IDLE);
    assign w_miss = w_idle & PC_READ & ~w_hit;

    // Hit data and stall are combinational for zero-latency hits; reset forces the stall low.
    assign INSTRUCTION  = (w_idle & w_hit) ? r_data[w_idx][{w_word, 5'b0} +: 32] : 32'h0;
    assign CPU_BUSYWAIT = RESET_N & (w_idle ? (PC_READ & ~w_hit) : 1'b1);
    assign MEM_READ     = (r_state == MEM_READ_S);
    assign MEM_ADDRESS  = MEM_READ ? r_miss_addr : 28'h0;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state     <= IDLE;
            r_armed     <= 1'b0;
            r_miss_addr <= 28'h0;
            r_valid     <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    // Flush takes priority over latching a miss; the CPU retries next cycle.
                    if (FLUSH) begin
                        r_valid <= '0;
                    end else if (w_miss) begin
                        r_miss_addr <= PC_ADDRESS[31:4];
                        r_state     <= MEM_READ_S;
                    end
                end
                MEM_READ_S: begin
                    if (MEM_BUSYWAIT) begin
                        r_armed <= 1'b1;
                    end
                    if (r_armed && !MEM_BUSYWAIT) begin
                        r_state <= UPDATE;
                    end
                end
                UPDATE: begin
                    r_valid[w_fill_idx] <= 1'b1;
                    r_armed             <= 1'b0;
                    r_state             <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Line payload and tags carry no reset; the valid bits guard them.
    always_ff @(posedge CLK) begin
        if (r_state == UPDATE) begin
            r_data[w_fill_idx] <= MEM_READDATA;
            r_tag[w_fill_idx]  <= w_fill_tag;
        end
    end

`ifdef ICACHE_PERF_EN
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            HIT_COUNT  <= 32'h0;
            MISS_COUNT <= 32'h0;
        end else begin
            if (w_idle && w_hit) begin
                HIT_COUNT <= HIT_COUNT + 32'd1;
            end
            if (w_miss && !FLUSH) begin
                MISS_COUNT <= MISS_COUNT + 32'd1;
            end
        end
    end
`else
    // Counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_icache_controller.sv
// Self-checking bench for icache_controller: table-driven hit vectors plus directed miss/flush/reset sequences.
module tb_icache_controller;
    localparam int LAT = 16;

    logic         CLK = 1'b0;
    logic         RESET_N;
    logic         PC_READ;
    logic [31:0]  PC_ADDRESS;
    logic [31:0]  INSTRUCTION;
    logic         CPU_BUSYWAIT;
    logic         FLUSH;
    logic         MEM_READ;
    logic [27:0]  MEM_ADDRESS;
    logic [127:0] MEM_READDATA;
    logic         MEM_BUSYWAIT;
`ifdef ICACHE_PERF_EN
    logic [31:0]  HIT_COUNT;
    logic [31:0]  MISS_COUNT;
`endif

    int checks = 0;
    int errors = 0;
    int mem_cnt = 0;

    icache_controller dut (
        .CLK          (CLK),
        .RESET_N      (RESET_N),
        .PC_READ      (PC_READ),
        .PC_ADDRESS   (PC_ADDRESS),
        .INSTRUCTION  (INSTRUCTION),
        .CPU_BUSYWAIT (CPU_BUSYWAIT),
        .FLUSH        (FLUSH),
        .MEM_READ     (MEM_READ),
        .MEM_ADDRESS  (MEM_ADDRESS),
        .MEM_READDATA (MEM_READDATA),
        .MEM_BUSYWAIT (MEM_BUSYWAIT)
`ifdef ICACHE_PERF_EN
        ,
        .HIT_COUNT    (HIT_COUNT),
        .MISS_COUNT   (MISS_COUNT)
`endif
    );

    always #5 CLK = ~CLK;

    // Block contents: block 0 holds a fixed program, others a recognisable address pattern.
    function automatic logic [127:0] blk(input logic [27:0] a);
        if (a == 28'h0)
            return {32'h0020F233, 32'h402081B3, 32'h00208133, 32'h01E100B3};
        return {a[15:0], 16'h3333, a[15:0], 16'h2222, a[15:0], 16'h1111, a[15:0], 16'h0000};
    endfunction

    // Memory holds busy for LAT cycles after READ rises and keeps the block latched through UPDATE.
    assign MEM_BUSYWAIT = MEM_READ && (mem_cnt < LAT);
    always @(posedge CLK) begin
        if (!MEM_READ) begin
            mem_cnt <= 0;
        end else begin
            if (mem_cnt < LAT) mem_cnt <= mem_cnt + 1;
            MEM_READDATA <= blk(MEM_ADDRESS);
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered at a negedge with a miss presented; returns at the negedge where the stall drops.
    task automatic wait_fill(input string name, input logic [27:0] exp_addr, input bit flush_mid);
        int n;
        @(posedge CLK);
        @(negedge CLK);
        check({name, " mem_read"}, 128'(MEM_READ), 128'(1));
        check({name, " mem_addr"}, 128'(MEM_ADDRESS), 128'(exp_addr));
        check({name, " busy"}, 128'(CPU_BUSYWAIT), 128'(1));
        if (flush_mid) FLUSH = 1'b1;
        n = 1;
        while (CPU_BUSYWAIT && n < 100) begin
            @(posedge CLK);
            @(negedge CLK);
            FLUSH = 1'b0;
            n++;
        end
        check({name, " fill cycles"}, 128'(n), 128'(LAT + 3));
    endtask

    typedef struct {
        logic        rd;
        logic [31:0] pc;
        logic        busy;
        logic [31:0] instr;
    } vec_t;

    vec_t vecs [6];

    initial begin
        vecs[0] = '{1'b1, 32'h0000_0000, 1'b0, 32'h01E100B3};
        vecs[1] = '{1'b1, 32'h0000_0004, 1'b0, 32'h00208133};
        vecs[2] = '{1'b1, 32'h0000_0008, 1'b0, 32'h402081B3};
        vecs[3] = '{1'b1, 32'h0000_000C, 1'b0, 32'h0020F233};
        vecs[4] = '{1'b0, 32'h0000_0004, 1'b0, 32'h0};
        vecs[5] = '{1'b0, 32'h0000_0080, 1'b0, 32'h0};

        RESET_N = 1'b0; PC_READ = 1'b1; PC_ADDRESS = 32'h0; FLUSH = 1'b0;
        repeat (3) @(negedge CLK);
        #1;
        check("reset busy", 128'(CPU_BUSYWAIT), 128'(0));
        check("reset mem_read", 128'(MEM_READ), 128'(0));
        check("reset mem_addr", 128'(MEM_ADDRESS), 128'(0));
        check("reset instr", 128'(INSTRUCTION), 128'(0));

        // Cold miss on PC 0.
        @(negedge CLK);
        RESET_N = 1'b1;
        #1;
        check("cold busy", 128'(CPU_BUSYWAIT), 128'(1));
        check("cold no read yet", 128'(MEM_READ), 128'(0));
        wait_fill("cold", 28'h0, 1'b0);

        // Replayed fetch and same-line hits.
        foreach (vecs[i]) begin
            PC_READ = vecs[i].rd;
            PC_ADDRESS = vecs[i].pc;
            #1;
            check($sformatf("vec%0d busy", i), 128'(CPU_BUSYWAIT), 128'(vecs[i].busy));
            check($sformatf("vec%0d instr", i), 128'(INSTRUCTION), 128'(vecs[i].instr));
            check($sformatf("vec%0d mem_read", i), 128'(MEM_READ), 128'(0));
            @(posedge CLK);
            @(negedge CLK);
        end
`ifdef ICACHE_PERF_EN
        check("perf hits", 128'(HIT_COUNT), 128'(4));
        check("perf misses", 128'(MISS_COUNT), 128'(1));
`endif

        // Conflict on index 0: tag 1 evicts tag 0, then tag 0 misses again.
        PC_READ = 1'b1; PC_ADDRESS = 32'h0000_0080;
        #1;
        check("conflict busy", 128'(CPU_BUSYWAIT), 128'(1));
        check("conflict instr", 128'(INSTRUCTION), 128'(0));
        wait_fill("conflict", 28'h0000008, 1'b0);
        check("conflict data", 128'(INSTRUCTION), 128'(32'h00080000));
        @(posedge CLK);
        @(negedge CLK);
        PC_ADDRESS = 32'h0;
        #1;
        check("refetch0 busy", 128'(CPU_BUSYWAIT), 128'(1));
        wait_fill("refetch0", 28'h0, 1'b0);
        check("refetch0 data", 128'(INSTRUCTION), 128'(32'h01E100B3));

        // Flush in IDLE invalidates; flush during the refill is ignored.
        @(posedge CLK);
        @(negedge CLK);
        PC_READ = 1'b0; FLUSH = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        FLUSH = 1'b0; PC_READ = 1'b1; PC_ADDRESS = 32'h0000_0004;
        #1;
        check("flush miss", 128'(CPU_BUSYWAIT), 128'(1));
        wait_fill("flushfill", 28'h0, 1'b1);
        check("flushfill data", 128'(INSTRUCTION), 128'(32'h00208133));
        @(posedge CLK);
        @(negedge CLK);
        PC_ADDRESS = 32'h0000_0008;
        #1;
        check("post-flush hit busy", 128'(CPU_BUSYWAIT), 128'(0));
        check("post-flush hit data", 128'(INSTRUCTION), 128'(32'h402081B3));

        // Reset in the middle of a refill.
        @(negedge CLK);
        PC_ADDRESS = 32'h0000_0010;
        @(posedge CLK);
        @(negedge CLK);
        check("midmiss mem_read", 128'(MEM_READ), 128'(1));
        check("midmiss mem_addr", 128'(MEM_ADDRESS), 128'(28'h1));
        #2;
        RESET_N = 1'b0;
        #1;
        check("rst mem_read", 128'(MEM_READ), 128'(0));
        check("rst mem_addr", 128'(MEM_ADDRESS), 128'(0));
        check("rst busy", 128'(CPU_BUSYWAIT), 128'(0));
        check("rst instr", 128'(INSTRUCTION), 128'(0));
        @(negedge CLK);
        RESET_N = 1'b1; PC_ADDRESS = 32'h0;
        #1;
        check("post-rst busy", 128'(CPU_BUSYWAIT), 128'(1));
        wait_fill("post-rst", 28'h0, 1'b0);
        check("post-rst data", 128'(INSTRUCTION), 128'(32'h01E100B3));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/icache_controller.md
Name: icache_controller

Overview:
Direct-mapped instruction cache and controller between the CPU fetch stage and the 128-bit-block instruction memory. It serves 32-bit instruction fetches from local line storage on a hit. On a miss it stalls the CPU, runs a block read on the memory handshake (MEM_READ/MEM_BUSYWAIT), fills the line, then replays the fetch.

Parameters:
NUM_LINES, 8, number of cache lines (power of two, at least 2)
INDEX_BITS, 3, log2(NUM_LINES); tag width = 28 - INDEX_BITS

Ports:
CLK  input  1  clock, all state updates on posedge
RESET_N  input  1  asynchronous, active-low reset
PC_READ  input  1  CPU fetch request
PC_ADDRESS  input  32  fetch byte address; [1:0] ignored, [3:2] word select, [3+INDEX_BITS:4] index, [31:4+INDEX_BITS] tag
INSTRUCTION  output  32  fetched instruction, valid when PC_READ=1 and CPU_BUSYWAIT=0
CPU_BUSYWAIT  output  1  CPU stall
FLUSH  input  1  invalidate all lines
MEM_READ  output  1  block read request to instruction memory
MEM_ADDRESS  output  28  block address = PC_ADDRESS[31:4] latched at miss
MEM_READDATA  input  128  returned block, byte 0 in [7:0]
MEM_BUSYWAIT  input  1  memory busy

Behaviour:
- Storage: per line a valid bit, a tag and 128 data bits. Word w of a line = data[32w+31:32w].
- hit = PC_READ & valid[idx] & (tag[idx] == PC tag). Evaluated combinationally.
- States: IDLE, MEM_READ_S, UPDATE. Encoded in 2 bits.
- IDLE
  - Hit: INSTRUCTION = selected word and CPU_BUSYWAIT=0 in the same cycle (0-cycle hit latency).
  - Miss with PC_READ=1: CPU_BUSYWAIT=1 combinationally. At the posedge, latch PC_ADDRESS[31:4] into miss_addr and go to MEM_READ_S.
  - PC_READ=0: CPU_BUSYWAIT=0, INSTRUCTION=0.
- MEM_READ_S
  - MEM_READ=1, MEM_ADDRESS=miss_addr, CPU_BUSYWAIT=1.
  - armed flag: set on any posedge where MEM_BUSYWAIT=1.
  - Go to UPDATE on a posedge where armed=1 and MEM_BUSYWAIT=0.
  - This tolerates memory that raises busy a delta after READ.
- UPDATE (1 cycle)
  - MEM_READ=0, CPU_BUSYWAIT=1.
  - At the posedge, write MEM_READDATA, miss_addr tag and valid=1 into line miss_addr[INDEX_BITS-1:0]. Clear armed. Go to IDLE.
- After UPDATE, IDLE re-evaluates the current PC_ADDRESS. A PC that changed mid-miss simply misses or hits anew.
- Miss penalty = memory busy cycles + 2 cycles.
- MEM_ADDRESS = 0 whenever MEM_READ=0.
- FLUSH
  - Sampled only in IDLE: clears all valid bits at the posedge.
  - FLUSH with a simultaneous miss: flush wins; no miss latched this cycle. The CPU still sees CPU_BUSYWAIT=1 and retries next cycle.
  - Ignored in MEM_READ_S and UPDATE.
- Reset (RESET_N low, any time including mid-miss): immediately state=IDLE, all valid=0, armed=0, miss_addr=0, MEM_READ=0, MEM_ADDRESS=0, CPU_BUSYWAIT=0, INSTRUCTION=0.
- Line data and tags are not reset.
- A refill never writes a line other than the latched index. Wrap of PC_ADDRESS at 0xFFFFFFF0 needs no special case.

Optional Feature:
ICACHE_PERF_EN
- Defined: adds outputs HIT_COUNT[31:0] and MISS_COUNT[31:0].
  - HIT_COUNT increments on each posedge in IDLE with hit=1.
  - MISS_COUNT increments on each IDLE to MEM_READ_S transition.
  - Both wrap at 2^32 to 0 and are cleared by RESET_N.
  - A replayed fetch after refill counts as a hit.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: hold RESET_N=0 with PC_READ=1 -> CPU_BUSYWAIT=0, MEM_READ=0, MEM_ADDRESS=0, INSTRUCTION=0.
- Cold miss: after reset, PC_READ=1, PC=0x00000000, memory block word0=0x01E100B3 with 16-cycle busy.
  - CPU_BUSYWAIT=1 and MEM_READ=1 with MEM_ADDRESS=0x0000000 next cycle.
  - After busy falls, one UPDATE cycle, then INSTRUCTION=0x01E100B3 and CPU_BUSYWAIT=0.
- Same-line hits: PC=0x4, 0x8, 0xC on consecutive cycles -> words 1..3 of the block returned with CPU_BUSYWAIT=0, MEM_READ never asserted.
- Conflict: PC=0x80 (index 0, tag 1) -> miss with MEM_ADDRESS=0x0000008; then PC=0x0 -> miss again with MEM_ADDRESS=0x0000000.
- Flush:
  - FLUSH=1 for one cycle in IDLE, then PC=0x4 -> miss.
  - FLUSH=1 during MEM_READ_S -> ignored; refilled line hits afterwards.
- Reset mid-miss: drop RESET_N while MEM_READ=1 -> MEM_READ=0 immediately. After release, PC=0x0 misses again.
- With ICACHE_PERF_EN: the cold-miss plus 3-hit sequence -> MISS_COUNT=1, HIT_COUNT=4.
